// File: rtl/pipe_div.sv
`default_nettype none
// ============================================================================
// Module      : pipe_div
// Description : Fully pipelined unsigned restoring divider; one quotient bit
//               per stage, DW-cycle latency, one operation per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_div #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold,
    input  logic          in_valid,
    input  logic [DW-1:0] div_a,
    input  logic [VW-1:0] div_b,
    output logic          out_valid,
    output logic [DW-1:0] div_q,
    output logic [VW-1:0] div_r,
    output logic          div_zero
);

    logic          r_valid [DW];
    logic [VW-1:0] r_dvsr  [DW];
    logic          r_zero  [DW];
    logic [DW-1:0] r_dvnd  [DW];
    logic [VW:0]   r_rem   [DW];
    logic [DW-1:0] r_quo   [DW];

    logic          w_valid_nxt [DW];
    logic [VW-1:0] w_dvsr_nxt  [DW];
    logic          w_zero_nxt  [DW];
    logic [DW-1:0] w_dvnd_nxt  [DW];
    logic [VW:0]   w_rem_nxt   [DW];
    logic [DW-1:0] w_quo_nxt   [DW];

    logic          r_out_valid;
    logic [DW-1:0] r_out_q;
    logic [VW-1:0] r_out_r;
    logic          r_out_zero;

    for (genvar k = 0; k < DW; k++) begin : g_stage
        logic          w_v_in;
        logic [VW-1:0] w_d_in;
        logic          w_z_in;
        logic [DW-1:0] w_a_in;
        logic [VW-1:0] w_r_in;
        logic [DW-1:0] w_q_in;
        logic [VW:0]   w_t;
        logic          w_ge;
        logic          w_unused_msb;

        if (k == 0) begin : g_head
            assign w_v_in = in_valid;
            assign w_d_in = div_b;
            assign w_z_in = (div_b == '0);
            assign w_a_in = div_a;
            assign w_r_in = '0;
            assign w_q_in = '0;
        end else begin : g_body
            assign w_v_in = r_valid[k-1];
            assign w_d_in = r_dvsr[k-1];
            assign w_z_in = r_zero[k-1];
            assign w_a_in = r_dvnd[k-1];
            assign w_r_in = r_rem[k-1][VW-1:0];
            assign w_q_in = r_quo[k-1];
        end

        // The remainder is always below the divisor, so only its low VW bits
        // ever feed the next shift; the extra bit only holds the pre-compare value.
        assign w_unused_msb = r_rem[k][VW];

        assign w_t  = {w_r_in, w_a_in[DW-1]};
        assign w_ge = (w_t >= {1'b0, w_d_in});

        assign w_valid_nxt[k] = w_v_in;
        assign w_dvsr_nxt[k]  = w_d_in;
        assign w_zero_nxt[k]  = w_z_in;
        assign w_dvnd_nxt[k]  = w_a_in << 1;
        assign w_rem_nxt[k]   = w_ge ? (w_t - {1'b0, w_d_in}) : w_t;
        assign w_quo_nxt[k]   = (w_q_in << 1) | DW'(w_ge);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DW; k++) begin
                r_valid[k] <= 1'b0;
            end
        end else if (!hold) begin
            for (int k = 0; k < DW; k++) begin
                r_valid[k] <= w_valid_nxt[k];
                r_dvsr[k]  <= w_dvsr_nxt[k];
                r_zero[k]  <= w_zero_nxt[k];
                r_dvnd[k]  <= w_dvnd_nxt[k];
                r_rem[k]   <= w_rem_nxt[k];
                r_quo[k]   <= w_quo_nxt[k];
            end
        end
    end

    // Divide-by-zero result is forced here, independent of the arithmetic path.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_q     <= '0;
            r_out_r     <= '0;
            r_out_zero  <= 1'b0;
        end else if (!hold) begin
            r_out_valid <= r_valid[DW-1];
            if (r_valid[DW-1]) begin
                if (r_zero[DW-1]) begin
                    r_out_q    <= '1;
                    r_out_r    <= '0;
                    r_out_zero <= 1'b1;
                end else begin
                    r_out_q    <= r_quo[DW-1];
                    r_out_r    <= r_rem[DW-1][VW-1:0];
                    r_out_zero <= 1'b0;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign div_q     = r_out_q;
    assign div_r     = r_out_r;
    assign div_zero  = r_out_zero;

endmodule
`default_nettype wire

// File: doc/pipe_div.md
# pipe_div

Fully pipelined unsigned restoring divider. It accepts one DW-bit dividend and one VW-bit divisor per cycle and returns the quotient and remainder a fixed DW cycles later. It is the inverse datapath to the team's pipelined 4x4 multiplier: an 8-bit product divided by either 4-bit factor recovers the other factor. Throughput is one operation per cycle, and a global hold freezes the pipe.

## Interface

Parameters:
- DW, 8: dividend and quotient width; also the pipeline depth.
- VW, 4: divisor and remainder width; VW ≤ DW.

Ports:
- clk, input, 1: single clock; all registers update on the rising edge.
- rst, input, 1: reset is synchronous and active-high.
- hold, input, 1: when 1, every pipeline register keeps its value and inputs are ignored.
- in_valid, input, 1: div_a and div_b carry an operation this cycle.
- div_a, input, DW: dividend, unsigned.
- div_b, input, VW: divisor, unsigned.
- out_valid, output, 1: div_q, div_r and div_zero are valid this cycle.
- div_q, output, DW: quotient.
- div_r, output, VW: remainder.
- div_zero, output, 1: the result belongs to an operation with div_b = 0.

## Operation

- The pipe has DW registered stages, S0..S(DW-1). Each stage carries:
  - a valid bit;
  - the divisor (VW bits);
  - a zero flag;
  - the unconsumed dividend bits;
  - a partial remainder, VW+1 bits wide to hold the shifted value before compare;
  - the partial quotient.
- Stage k resolves dividend bit DW-1-k:
  - form t = {rem[VW-1:0], next dividend bit};
  - if t ≥ {1'b0, divisor}: rem = t − divisor and the quotient bit is 1;
  - otherwise rem = t and the quotient bit is 0.
- S0 takes its inputs from the ports with rem = 0. The zero flag is set in S0 as (div_b == 0) and then travels with the operation.
- Output registers are driven from the final stage:
  - out_valid = final-stage valid.
  - Normal case: div_q = quotient, div_r = rem[VW-1:0].
  - Zero flag set: div_q = all ones, div_r = 0, div_zero = 1. This override is applied at the output and must not depend on the arithmetic path.
- Invariants for every valid result with div_zero = 0:
  - div_q·div_b + div_r == div_a;
  - div_r < div_b.
- Operations with in_valid = 0 propagate as bubbles: valid bit 0, data don't-care. When out_valid = 0, div_q, div_r and div_zero hold their previous values.
- The pipe has no backpressure and no in_ready; the consumer must accept every out_valid cycle.

## Timing

- Reset (rst = 1 at a rising edge):
  - out_valid, div_q, div_r and div_zero all become 0 at that edge;
  - every stage valid bit clears;
  - rst has priority over hold.
- Latency:
  - an operation sampled at edge t (in_valid = 1, hold = 0) appears with out_valid = 1 after edge t+DW, which is edge t+8 at the defaults;
  - out_valid stays high for exactly one cycle per operation, provided hold = 0.
- Throughput: back-to-back in_valid produces back-to-back out_valid, in order, with no gaps.
- hold:
  - with hold = 1 at an edge, no stage or output register changes; out_valid keeps its current level, so a result can be presented for several cycles;
  - in_valid is ignored during hold, and the sender must re-present the operation;
  - releasing hold resumes exactly where the pipe stopped.
- Reset mid-operation: every in-flight operation is discarded; none produce out_valid after rst deasserts.
- in_valid may rise in the same cycle that rst falls. The first edge with rst = 0 samples the inputs normally.

## Test plan

- Single operation: 200 / 7 → after 8 edges out_valid = 1 for 1 cycle, div_q = 28, div_r = 4, div_zero = 0.
- Corner values:
  - 255 / 1 → q = 255, r = 0;
  - 0 / 15 → q = 0, r = 0;
  - 225 / 15 → q = 15, r = 0;
  - 14 / 15 → q = 0, r = 14.
- Divide by zero: 100 / 0 → div_zero = 1, div_q = 255, div_r = 0.
  - Apply it back-to-back with 50 / 5. The next result is q = 10, r = 0, div_zero = 0, with no flag leakage.
- Streaming: 64 random operations on consecutive cycles with no gaps → 64 consecutive out_valid cycles, in order, each satisfying the invariants.
- Hold: issue 3 operations, then assert hold for 5 cycles at cycle 4 while toggling in_valid and data.
  - Outputs and out_valid are frozen during hold.
  - The 3 results emerge after release with total latency 8 + 5.
  - No spurious operations appear.
- Reset mid-stream: rst for 1 cycle while 4 operations are in flight → all outputs read 0 the next cycle, no out_valid for the dropped operations.
  - A new operation 81 / 9 issued right after reset returns q = 9, r = 0 with latency 8.
